epu_pass_sched: RTL and testbench

- Sequences the EPU encode datapath: one colour pass per input block in order Y, Cb, Cr (mode codes 1, 3, 2).
- For each pass it issues a fixed read burst of pixel words to the input SRAM, then waits for the downstream RLE to report end of block.
- Advances the mode and the block base address, and signals completion after the last Cr pass of the last block.
- Sits between the CPU/DMA start register and the toYCrCb/DCT/RLE/H_FF chain, replacing ad-hoc address and mode bookkeeping.

---
 rtl/epu_pass_sched.sv | 194 +++++++++++++++++++
 tb/tb_epu_pass_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/epu_pass_sched.sv
// ---------------------------------------------------------------------------
// epu_pass_sched
//
// Sequences the EPU encode datapath: for every 8x8 input block it runs three
// colour passes in the order Y (mode 1), Cb (mode 3), Cr (mode 2). Each pass
// issues a fixed burst of WORDS_PER_BLOCK reads to the input SRAM, then waits
// for the RLE stage to report end of block before moving on. After the Cr
// pass of the last block a one-cycle done pulse is produced.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       frame start pulse, honoured only in IDLE
//   abort       frame abort, highest priority, behaves like rst
//   blk_done    one-cycle end-of-block pulse from RLE
//   rd_stall    downstream cannot accept a word this cycle
//   rd_en       SRAM read strobe
//   rd_addr     SRAM word address
//   mode        current pass (1=Y, 3=Cb, 2=Cr, 0 when idle)
//   pass_start  pulse on the first issued read of each pass
//   blk_idx     current block index
//   last_pass   high during the Cr pass of the final block
//   busy        high in every state except IDLE
//   done        one-cycle frame-complete pulse
//   stall_cnt   stalled-read cycle counter
//   state_dbg   current FSM state, for checkers and debug visibility
//
// Build option: define EPU_PASS_SCHED_PERF_EN to enable the stall_cnt
// counter; otherwise stall_cnt is tied to zero.
//
// Read handshake: a word is transferred in exactly the cycles where rd_en=1.
// rd_en is only asserted in FETCH when rd_stall=0; while rd_stall=1 the
// address is held so the same word is presented again once the stall clears.
// ---------------------------------------------------------------------------
module epu_pass_sched #(
    parameter int BLOCK_NUM       = 64,
    parameter int WORDS_PER_BLOCK = 16,
    parameter int ADDR_W          = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              blk_done,
    input  logic              rd_stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        mode,
    output logic              pass_start,
    output logic [7:0]        blk_idx,
    output logic              last_pass,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stall_cnt,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ADV   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_Y   = 2'd1;
    localparam logic [1:0] MODE_CB  = 2'd3;
    localparam logic [1:0] MODE_CR  = 2'd2;

    localparam logic [8:0]        LAST_WORD  = 9'(WORDS_PER_BLOCK - 1);
    localparam logic [7:0]        LAST_BLK   = 8'(BLOCK_NUM - 1);
    localparam logic [ADDR_W-1:0] BLK_STRIDE = ADDR_W'(WORDS_PER_BLOCK);

    logic [2:0]        state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        word_q;
    logic              pending_q;
    logic [1:0]        mode_q;
    logic [7:0]        blk_q;

    logic              rd_issue;
    logic              last_blk;
    logic [ADDR_W-1:0] next_base;

    assign rd_issue  = (state_q == S_FETCH) && !rd_stall;
    assign last_blk  = (blk_q == LAST_BLK);
    assign next_base = base_q + BLK_STRIDE;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            word_q    <= '0;
            pending_q <= 1'b0;
            mode_q    <= MODE_OFF;
            blk_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        base_q    <= '0;
                        addr_q    <= '0;
                        word_q    <= '0;
                        pending_q <= 1'b0;
                        mode_q    <= MODE_Y;
                        blk_q     <= '0;
                    end
                end
                S_FETCH: begin
                    // An early end-of-block is remembered; the burst still completes.
                    if (blk_done) pending_q <= 1'b1;
                    if (rd_issue) begin
                        if (word_q == LAST_WORD) begin
                            // Address stays on the last word for the WAIT phase.
                            state_q <= S_WAIT;
                        end else begin
                            word_q <= word_q + 9'd1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (blk_done || pending_q) begin
                        pending_q <= 1'b0;
                        state_q   <= S_ADV;
                    end
                end
                S_ADV: begin
                    if (mode_q == MODE_CR && last_blk) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_FETCH;
                        word_q  <= '0;
                        case (mode_q)
                            MODE_Y: begin
                                mode_q <= MODE_CB;
                                addr_q <= base_q;
                            end
                            MODE_CB: begin
                                mode_q <= MODE_CR;
                                addr_q <= base_q;
                            end
                            default: begin
                                // Cr -> Y wraps onto the next block.
                                mode_q <= MODE_Y;
                                base_q <= next_base;
                                addr_q <= next_base;
                                blk_q  <= blk_q + 8'd1;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    mode_q  <= MODE_OFF;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef EPU_PASS_SCHED_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (state_q == S_FETCH && rd_stall && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign rd_en      = rd_issue;
    assign rd_addr    = addr_q;
    assign mode       = mode_q;
    assign pass_start = rd_issue && (word_q == 9'd0);
    assign blk_idx    = blk_q;
    assign last_pass  = (state_q == S_FETCH || state_q == S_WAIT || state_q == S_ADV)
                        && (mode_q == MODE_CR) && last_blk;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_epu_pass_sched.sv
module tb_epu_pass_sched;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ADV   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

`ifdef EPU_PASS_SCHED_PERF_EN
  localparam int STALL_EXP = 3;
`else
  localparam int STALL_EXP = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: 2 blocks x 16 words ----------------
  logic        start_a = 0, abort_a = 0, blk_done_a = 0, rd_stall_a = 0;
  logic        rd_en_a, pass_start_a, last_pass_a, busy_a, done_a;
  logic [11:0] rd_addr_a;
  logic [1:0]  mode_a;
  logic [7:0]  blk_idx_a;
  logic [15:0] stall_cnt_a;
  logic [2:0]  state_a;

  epu_pass_sched #(.BLOCK_NUM(2), .WORDS_PER_BLOCK(16), .ADDR_W(12)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .blk_done(blk_done_a),
    .rd_stall(rd_stall_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .mode(mode_a),
    .pass_start(pass_start_a), .blk_idx(blk_idx_a), .last_pass(last_pass_a),
    .busy(busy_a), .done(done_a), .stall_cnt(stall_cnt_a), .state_dbg(state_a)
  );

  // ---------------- DUT B: 1 block x 1 word ----------------
  logic        start_b = 0, abort_b = 0, blk_done_b = 0, rd_stall_b = 0;
  logic        rd_en_b, pass_start_b, last_pass_b, busy_b, done_b;
  logic [11:0] rd_addr_b;
  logic [1:0]  mode_b;
  logic [7:0]  blk_idx_b;
  logic [15:0] stall_cnt_b;
  logic [2:0]  state_b;

  epu_pass_sched #(.BLOCK_NUM(1), .WORDS_PER_BLOCK(1), .ADDR_W(12)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .blk_done(blk_done_b),
    .rd_stall(rd_stall_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .mode(mode_b),
    .pass_start(pass_start_b), .blk_idx(blk_idx_b), .last_pass(last_pass_b),
    .busy(busy_b), .done(done_b), .stall_cnt(stall_cnt_b), .state_dbg(state_b)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [21:0] exp_q[$];   // {blk_idx, mode, rd_addr} per issued read
  int reads_a = 0, ps_a = 0, done_cnt_a = 0, lp_a = 0;
  int reads_b = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_en_a) begin
      reads_a++;
      if (last_pass_a) lp_a++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL read_seq: got %0h expected none", {blk_idx_a, mode_a, rd_addr_a});
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        assert ({blk_idx_a, mode_a, rd_addr_a} === e) else begin
          fails++;
          $error("FAIL read_seq: got %0h expected %0h", {blk_idx_a, mode_a, rd_addr_a}, e);
        end
      end
    end
    if (pass_start_a) ps_a++;
    if (done_a) done_cnt_a++;
    if (rd_en_b) begin
      reads_b++;
      chk("b_addr", 32'(rd_addr_b), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass(input int blk, input logic [1:0] m, input int nwords);
    for (int w = 0; w < nwords; w++)
      exp_q.push_back({8'(blk), m, 12'(blk * 16 + w)});
  endtask

  task automatic push_frame();
    for (int b = 0; b < 2; b++) begin
      push_pass(b, 2'd1, 16);
      push_pass(b, 2'd3, 16);
      push_pass(b, 2'd2, 16);
    end
  endtask

  // Starts at the first FETCH sample point of a pass, ends at the ADV sample point.
  task automatic run_pass(input int blk, input bit stall_en, input bit early_en, input bit poke_start);
    int reads;
    int stalls;
    int guard;
    logic [11:0] base;
    reads = 0;
    stalls = 0;
    guard = 0;
    base = 12'(blk * 16);
    while (reads < 16 && guard < 200) begin
      rd_stall_a = stall_en && (rd_addr_a == base + 12'd5) && (stalls < 3);
      blk_done_a = early_en && (reads == 10);
      #1;
      if (rd_stall_a) begin
        stalls++;
        chk("stall_rd_en", 32'(rd_en_a), 32'd0);
        chk("stall_addr", 32'(rd_addr_a), 32'(base + 12'd5));
      end
      if (rd_en_a) reads++;
      guard++;
      cyc();
    end
    rd_stall_a = 0;
    blk_done_a = 0;
    #1;
    chk("burst_len", 32'(reads), 32'd16);
    chk("wait_state", 32'(state_a), 32'(S_WAIT));
    chk("wait_rd_en", 32'(rd_en_a), 32'd0);
    chk("wait_addr", 32'(rd_addr_a), 32'(base + 12'd15));
    if (early_en) begin
      cyc();
    end else begin
      if (poke_start) start_a = 1;
      repeat (4) cyc();
      start_a = 0;
      blk_done_a = 1;
      cyc();
      blk_done_a = 0;
    end
    chk("adv_state", 32'(state_a), 32'(S_ADV));
  endtask

  task automatic run_frame(input int stall_pass, input int early_pass, input int poke_pass);
    int r0, p0, d0, l0;
    r0 = reads_a; p0 = ps_a; d0 = done_cnt_a; l0 = lp_a;
    push_frame();
    start_a = 1;
    cyc();
    start_a = 0;
    chk("first_addr", 32'(rd_addr_a), 32'd0);
    chk("first_mode", 32'(mode_a), 32'd1);
    chk("first_pass_start", 32'(pass_start_a), 32'd1);
    for (int p = 0; p < 6; p++) begin
      run_pass(p / 3, p == stall_pass, p == early_pass, p == poke_pass);
      cyc();
      if (p < 5) begin
        chk("gap_pass_start", 32'(pass_start_a), 32'd1);
      end else begin
        chk("done_pulse", 32'(done_a), 32'd1);
        chk("done_stall_cnt", 32'(stall_cnt_a), 32'(STALL_EXP * (stall_pass < 6 ? 1 : 0)));
      end
    end
    cyc();
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_mode", 32'(mode_a), 32'd0);
    chk("idle_done", 32'(done_a), 32'd0);
    chk("frame_reads", 32'(reads_a - r0), 32'd96);
    chk("frame_pass_starts", 32'(ps_a - p0), 32'd6);
    chk("frame_done_count", 32'(done_cnt_a - d0), 32'd1);
    chk("frame_last_pass_reads", 32'(lp_a - l0), 32'd16);
    chk("frame_exp_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    rst = 1;
    repeat (3) cyc();
    rst = 0;
    #1;
    chk("rst_rd_en", 32'(rd_en_a), 32'd0);
    chk("rst_addr", 32'(rd_addr_a), 32'd0);
    chk("rst_mode", 32'(mode_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_blk", 32'(blk_idx_a), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt_a), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);

    // Plain frame, no stalls.
    run_frame(99, 99, 99);

    // blk_done while idle is ignored.
    blk_done_a = 1;
    cyc();
    blk_done_a = 0;
    chk("idle_blk_done_busy", 32'(busy_a), 32'd0);
    chk("idle_blk_done_mode", 32'(mode_a), 32'd0);

    // Stall at word 5 of pass 0, early blk_done in pass 1, start poked in pass 3.
    run_frame(0, 1, 3);

    // Abort during the Cb pass of block 1.
    d0 = done_cnt_a;
    for (int b = 0; b < 1; b++) begin
      push_pass(0, 2'd1, 16);
      push_pass(0, 2'd3, 16);
      push_pass(0, 2'd2, 16);
    end
    push_pass(1, 2'd1, 16);
    push_pass(1, 2'd3, 4);
    start_a = 1;
    cyc();
    start_a = 0;
    for (int p = 0; p < 4; p++) begin
      run_pass(p / 3, 0, 0, 0);
      cyc();
    end
    chk("abort_pre_mode", 32'(mode_a), 32'd3);
    repeat (3) cyc();
    abort_a = 1;
    cyc();
    abort_a = 0;
    chk("abort_state", 32'(state_a), 32'(S_IDLE));
    chk("abort_rd_en", 32'(rd_en_a), 32'd0);
    chk("abort_addr", 32'(rd_addr_a), 32'd0);
    chk("abort_mode", 32'(mode_a), 32'd0);
    chk("abort_blk", 32'(blk_idx_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    repeat (5) cyc();
    chk("abort_no_done", 32'(done_cnt_a - d0), 32'd0);
    chk("abort_exp_empty", 32'(exp_q.size()), 32'd0);

    // Restart after abort begins again at address 0, mode 1.
    run_frame(99, 99, 99);

    // Minimal configuration: 1 block, 1 word.
    start_b = 1;
    cyc();
    start_b = 0;
    for (int p = 0; p < 3; p++) begin
      chk("b_rd_en", 32'(rd_en_b), 32'd1);
      chk("b_mode", 32'(mode_b), (p == 0) ? 32'd1 : (p == 1) ? 32'd3 : 32'd2);
      cyc();
      blk_done_b = 1;
      cyc();
      blk_done_b = 0;
      chk("b_adv", 32'(state_b), 32'(S_ADV));
      cyc();
    end
    chk("b_done", 32'(done_b), 32'd1);
    cyc();
    chk("b_idle", 32'(busy_b), 32'd0);
    chk("b_reads", 32'(reads_b), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
